// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer port arbiter: grant encoding and the
// requester state machines.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CPU,
    GNT_CLR
  } grant_e;

  typedef enum logic {
    C_IDLE,
    C_ACK
  } cpu_state_e;

  typedef enum logic [1:0] {
    CL_IDLE,
    CL_RUN,
    CL_DONE
  } clr_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Bulk-clear sequencer: walks a word counter from 0 to CLR_WORDS-1, advancing
// only when the arbiter grants the write slot.
module fb_clear_seq
  import fb_arb_pkg::*;
#(
  parameter int AW        = 12,
  parameter int CLR_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          slot_free,
  output logic          wr_req,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done
);

  // One extra counter bit so CLR_WORDS == 2**AW terminates without wrapping.
  localparam logic [AW:0] LAST = (AW+1)'(CLR_WORDS - 1);

  clr_state_e  state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CL_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = CL_RUN;
        end
      end
      CL_RUN: begin
        if (slot_free) begin
          cnt_d = cnt_q + (AW+1)'(1);
          if (cnt_q == LAST) state_d = CL_DONE;
        end
      end
      CL_DONE: state_d = CL_IDLE;
      default: state_d = CL_IDLE;
    endcase
  end

  assign wr_req = (state_q == CL_RUN);
  assign busy   = (state_q == CL_RUN);
  assign done   = (state_q == CL_DONE);
  assign addr   = cnt_q[AW-1:0];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: display > CPU > clear, one grant per
// cycle, read data steered back by the registered grant.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int             AW        = 12,
  parameter int             DW        = 8,
  parameter int             CLR_WORDS = 4096,
  parameter logic [DW-1:0]  CLR_VALUE = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_disp_req,
  input  logic [AW-1:0] i_disp_addr,
  output logic          o_disp_valid,
  output logic [DW-1:0] o_disp_data,
  input  logic          i_cpu_stb,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_adr,
  input  logic [DW-1:0] i_cpu_dat,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rdt,
  input  logic          i_clr_start,
  output logic          o_clr_busy,
  output logic          o_clr_done,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  grant_e        grant, gnt_q;
  cpu_state_e    cpu_state, cpu_state_d;
  logic          cpu_we_q;
  logic [DW-1:0] disp_hold_q, cpu_hold_q;
  logic          clr_wr_req, clr_busy, clr_done, clr_slot;
  logic [AW-1:0] clr_addr;

  fb_clear_seq #(
    .AW        (AW),
    .CLR_WORDS (CLR_WORDS)
  ) u_clear_seq (
    .clk       (i_clk),
    .rst       (i_rst),
    .start     (i_clr_start),
    .slot_free (clr_slot),
    .wr_req    (clr_wr_req),
    .addr      (clr_addr),
    .busy      (clr_busy),
    .done      (clr_done)
  );

  // The clear never competes with the CPU directly: CPU grants are blocked
  // while busy, so the clear only yields to display and an outstanding ack.
  always_comb begin
    grant = GNT_NONE;
    if (!i_rst) begin
      if (i_disp_req)                                        grant = GNT_DISP;
      else if (i_cpu_stb && !clr_busy && cpu_state == C_IDLE) grant = GNT_CPU;
      else if (clr_wr_req && cpu_state != C_ACK)              grant = GNT_CLR;
    end
  end

  assign clr_slot = (grant == GNT_CLR);

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    case (grant)
      GNT_DISP: begin
        o_ram_en   = 1'b1;
        o_ram_addr = i_disp_addr;
      end
      GNT_CPU: begin
        o_ram_en    = 1'b1;
        o_ram_we    = i_cpu_we;
        o_ram_addr  = i_cpu_adr;
        o_ram_wdata = i_cpu_dat;
      end
      GNT_CLR: begin
        o_ram_en    = 1'b1;
        o_ram_we    = 1'b1;
        o_ram_addr  = clr_addr;
        o_ram_wdata = CLR_VALUE;
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_state_d = cpu_state;
    case (cpu_state)
      C_IDLE:  if (grant == GNT_CPU) cpu_state_d = C_ACK;
      C_ACK:   cpu_state_d = C_IDLE;
      default: cpu_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cpu_state   <= C_IDLE;
      gnt_q       <= GNT_NONE;
      cpu_we_q    <= 1'b0;
      disp_hold_q <= '0;
      cpu_hold_q  <= '0;
    end else begin
      cpu_state <= cpu_state_d;
      gnt_q     <= grant;
      if (grant == GNT_CPU) cpu_we_q <= i_cpu_we;
      if (gnt_q == GNT_DISP) disp_hold_q <= i_ram_rdata;
      if (cpu_state == C_ACK && !cpu_we_q) cpu_hold_q <= i_ram_rdata;
    end
  end

  // Outputs are forced quiet while reset is held, even mid-transaction.
  assign o_disp_valid = !i_rst && (gnt_q == GNT_DISP);
  assign o_disp_data  = i_rst ? '0 : ((gnt_q == GNT_DISP) ? i_ram_rdata : disp_hold_q);
  assign o_cpu_ack    = !i_rst && (cpu_state == C_ACK);
  assign o_cpu_rdt    = i_rst ? '0 :
                        ((cpu_state == C_ACK && !cpu_we_q) ? i_ram_rdata : cpu_hold_q);
  assign o_clr_busy   = !i_rst && clr_busy;
  assign o_clr_done   = !i_rst && clr_done;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter with a 1-cycle-latency RAM model,
// vector table, hand-written corner sequences and expected-value queues.
module tb_fb_port_arbiter;

  localparam int            AW        = 12;
  localparam int            DW        = 8;
  localparam int            CLR_WORDS = 16;
  localparam logic [DW-1:0] CLR_VALUE = 8'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          cpu_stb, cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_dat;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdt;
  logic          clr_start, clr_busy, clr_done;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .AW(AW), .DW(DW), .CLR_WORDS(CLR_WORDS), .CLR_VALUE(CLR_VALUE)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_valid(disp_valid), .o_disp_data(disp_data),
    .i_cpu_stb(cpu_stb), .i_cpu_we(cpu_we), .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat),
    .o_cpu_ack(cpu_ack), .o_cpu_rdt(cpu_rdt),
    .i_clr_start(clr_start), .o_clr_busy(clr_busy), .o_clr_done(clr_done),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // RAM model: read-first, one cycle of read latency.
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 37 + 11);
  endfunction

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] disp_exp_q[$];
  logic [DW-1:0] cpu_exp_q[$];
  logic [AW-1:0] clr_exp_q[$];
  logic          prev_disp = 1'b0;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: actual=%s required=%s at %0t", name, act, req, $time);
  endtask

  // Output monitor: display latency/data, CPU read-back data, clear write order.
  always @(negedge clk) begin
    if (rst) begin
      prev_disp = 1'b0;
    end else begin
      check("disp_valid_latency", 32'(disp_valid), 32'(prev_disp));
      if (disp_valid) begin
        if (disp_exp_q.size() == 0) fail_now("disp_unexpected", "valid", "no valid");
        else check("disp_data", 32'(disp_data), 32'(disp_exp_q.pop_front()));
      end
      if (cpu_ack) begin
        if (cpu_exp_q.size() == 0) fail_now("cpu_ack_unexpected", "ack", "no ack");
        else check("cpu_rdt", 32'(cpu_rdt), 32'(cpu_exp_q.pop_front()));
      end
      if (ram_en && ram_we && clr_busy) begin
        if (clr_exp_q.size() == 0) fail_now("clr_write_unexpected", "write", "no write");
        else begin
          check("clr_addr", 32'(ram_addr), 32'(clr_exp_q.pop_front()));
          check("clr_wdata", 32'(ram_wdata), 32'(CLR_VALUE));
        end
      end
      prev_disp = disp_req;
    end
  end

  task automatic push_clear();
    for (int i = 0; i < CLR_WORDS; i++) begin
      clr_exp_q.push_back(AW'(i));
      model[i] = CLR_VALUE;
    end
  endtask

  task automatic push_cpu(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (we) begin
      cpu_exp_q.push_back(last_rd);
      model[adr] = dat;
    end else begin
      last_rd = model[adr];
      cpu_exp_q.push_back(last_rd);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat, output int cycles);
    push_cpu(we, adr, dat);
    @(posedge clk); #1;
    cpu_stb = 1'b1; cpu_we = we; cpu_adr = adr; cpu_dat = dat;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (cpu_ack) break;
      if (cycles >= 64) begin
        fail_now("cpu_ack_timeout", "no ack", "ack");
        break;
      end
    end
    @(posedge clk); #1;
    cpu_stb = 1'b0; cpu_we = 1'b0;
  endtask

  typedef struct {
    logic          disp;
    logic [AW-1:0] daddr;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, done_cyc, ack_cyc;

    rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_dat = '0; clr_start = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]  <= pat(i);
      model[i] = pat(i);
    end

    vecs[0] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00};
    vecs[1] = '{1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h010, 8'h00};
    vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h123, 8'h5A, 1'b1, 1'b1, 12'h123, 8'h5A};
    vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b0, 12'h123, 8'h00};
    vecs[4] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'hFFF, 8'h00};
    vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 8'hC3, 1'b1, 1'b1, 12'h000, 8'hC3};

    // Reset: a display request during reset must not reach the RAM.
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 12'h055;
    @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_flags", 32'({disp_valid, cpu_ack, clr_busy, clr_done}), 32'd0);
    @(posedge clk); #1; disp_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({ram_en, ram_we, ram_addr, ram_wdata, disp_valid, cpu_ack,
                                 clr_busy, clr_done}), 32'd0);
      check("idle_data", 32'({disp_data, cpu_rdt}), 32'd0);
      @(posedge clk); #1;
    end

    // Vector table: single-requester RAM drive, then no re-grant in the next cycle.
    for (int r = 0; r < 6; r++) begin
      if (vecs[r].disp) disp_exp_q.push_back(model[vecs[r].daddr]);
      else if (vecs[r].stb) push_cpu(vecs[r].we, vecs[r].adr, vecs[r].dat);
      @(posedge clk); #1;
      disp_req = vecs[r].disp; disp_addr = vecs[r].daddr;
      cpu_stb = vecs[r].stb; cpu_we = vecs[r].we; cpu_adr = vecs[r].adr; cpu_dat = vecs[r].dat;
      @(negedge clk);
      check($sformatf("vec%0d_en", r), 32'(ram_en), 32'(vecs[r].e_en));
      if (vecs[r].e_en) begin
        check($sformatf("vec%0d_we", r), 32'(ram_we), 32'(vecs[r].e_we));
        check($sformatf("vec%0d_addr", r), 32'(ram_addr), 32'(vecs[r].e_addr));
        if (vecs[r].e_we) check($sformatf("vec%0d_wdata", r), 32'(ram_wdata), 32'(vecs[r].e_wdata));
      end
      @(posedge clk); #1;
      disp_req = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_no_regrant", r), 32'(ram_en), 32'd0);
      check($sformatf("vec%0d_ack", r), 32'(cpu_ack), 32'(vecs[r].stb));
      @(posedge clk); #1;
      cpu_stb = 1'b0; cpu_we = 1'b0;
    end

    // CPU write then read: ack in the cycle after the grant, 2 cycles per access.
    cpu_access(1'b1, 12'h2AB, 8'h77, cyc);
    check("cpu_wr_cycles", 32'(cyc), 32'd2);
    cpu_access(1'b0, 12'h2AB, 8'h00, cyc);
    check("cpu_rd_cycles", 32'(cyc), 32'd2);
    check("cpu_rd_data", 32'(cpu_rdt), 32'h77);

    // Display and CPU in the same cycle: display first, CPU next, ack after.
    disp_exp_q.push_back(model[12'h010]);
    push_cpu(1'b0, 12'h123, 8'h00);
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 12'h010; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h123;
    @(negedge clk);
    check("sim_disp_grant", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b0, 12'h010}));
    @(posedge clk); #1;
    disp_req = 1'b0;
    @(negedge clk);
    check("sim_disp_valid", 32'(disp_valid), 32'd1);
    check("sim_cpu_grant", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b0, 12'h123}));
    check("sim_no_early_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sim_cpu_ack", 32'(cpu_ack), 32'd1);
    check("sim_cpu_rdt", 32'(cpu_rdt), 32'h5A);
    @(posedge clk); #1;
    cpu_stb = 1'b0;

    // Clear with no competing traffic; a CPU read raised mid-clear waits for done.
    push_clear();
    done_cyc = -1; ack_cyc = -1;
    @(posedge clk); #1;
    clr_start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      clr_start = 1'b0;
      if (ack_cyc >= 0) cpu_stb = 1'b0;
      if (c == 5) begin
        push_cpu(1'b0, 12'h123, 8'h00);
        cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h123;
      end
      @(negedge clk);
      if (c <= 16) begin
        check("clr1_write", 32'({ram_en, ram_we}), 32'd3);
        check("clr1_busy", 32'(clr_busy), 32'd1);
      end
      if (c == 17) check("clr1_busy_drop", 32'(clr_busy), 32'd0);
      if (clr_done) begin
        if (done_cyc < 0) done_cyc = c;
        else fail_now("clr1_done_pulse", "repeat", "single");
      end
      if (cpu_ack && ack_cyc < 0) ack_cyc = c;
    end
    cpu_stb = 1'b0;
    check("clr1_done_cycle", 32'(done_cyc), 32'd17);
    check("clr1_cpu_ack_cycle", 32'(ack_cyc), 32'd18);
    check("clr1_all_written", 32'(clr_exp_q.size()), 32'd0);

    // Clear interleaved with display requests every second cycle.
    push_clear();
    done_cyc = -1;
    @(posedge clk); #1;
    clr_start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      clr_start = 1'b0;
      disp_req = (c % 2 == 1);
      disp_addr = AW'(12'h100 + c);
      if (disp_req) disp_exp_q.push_back(model[disp_addr]);
      @(negedge clk);
      if (disp_req) check("clr2_disp_grant", 32'({ram_en, ram_we, ram_addr}),
                          32'({1'b1, 1'b0, disp_addr}));
      else if (c <= 32) check("clr2_free_slot_write", 32'({ram_en, ram_we}), 32'd3);
      if (clr_done) begin
        done_cyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    disp_req = 1'b0;
    check("clr2_done_cycle", 32'(done_cyc), 32'd33);
    check("clr2_all_written", 32'(clr_exp_q.size()), 32'd0);

    // Reset with the counter at 7, then a fresh clear restarts from address 0.
    push_clear();
    @(posedge clk); #1;
    clr_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      clr_start = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clr_exp_q.delete();
    @(negedge clk);
    check("rst_mid_clr_en", 32'(ram_en), 32'd0);
    check("rst_mid_clr_flags", 32'({clr_busy, clr_done}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_clr_idle", 32'({ram_en, clr_busy, clr_done}), 32'd0);
      @(posedge clk); #1;
    end
    push_clear();
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(negedge clk);
    check("restart_addr0", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b1, 12'h000}));
    done_cyc = -1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (clr_done) begin
        done_cyc = c;
        break;
      end
    end
    check("restart_done_cycle", 32'(done_cyc), 32'd17);
    check("restart_all_written", 32'(clr_exp_q.size()), 32'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("disp_queue_drained", 32'(disp_exp_q.size()), 32'd0);
    check("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
